// File: rtl/idu_stage.sv
// RISC-V decode stage: combinational decode of inst_i captured into a one-deep output
// register, with a serialising hold after ecall/ebreak until the back end reports completion.
module idu_stage #(
  parameter int XLEN  = 64,
  parameter bit HAS_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  input  logic            sys_done_i,
  output logic [XLEN-1:0] pc_o,
  output logic [11:0]     opinfo_o,
  output logic [9:0]      alu_o,
  output logic [7:0]      mdu_o,
  output logic [5:0]      branch_o,
  output logic [6:0]      load_o,
  output logic [3:0]      store_o,
  output logic [1:0]      sys_o,
  output logic            illegal_o,
  output logic            wen_reg_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [XLEN-1:0] imm_o
);

  localparam bit RV64 = (XLEN == 64);

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {EMPTY, FULL, SERIAL} state_t;
  state_t state;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        shift_hi_zero;
  logic        shift_hi_sra;
  logic [11:0] opinfo_d;
  logic [9:0]  alu_d;
  logic [7:0]  mdu_d;
  logic [5:0]  br_d;
  logic [6:0]  ld_d;
  logic [3:0]  st_d;
  logic [1:0]  sys_d;
  logic        illegal_d;
  logic        wen_d;
  logic [31:0] imm32;
  logic [5:0]  shamt_d;
  logic        use_shamt;
  logic [XLEN-1:0] imm_d;
  logic        accept;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];

  // RV32 shifts must also have shamt[5] clear, so the upper-field check widens by one bit.
  assign shift_hi_zero = RV64 ? (inst_i[31:26] == 6'b000000) : (inst_i[31:25] == 7'b0000000);
  assign shift_hi_sra  = RV64 ? (inst_i[31:26] == 6'b010000) : (inst_i[31:25] == 7'b0100000);

  always_comb begin
    opinfo_d  = '0;
    alu_d     = '0;
    mdu_d     = '0;
    br_d      = '0;
    ld_d      = '0;
    st_d      = '0;
    sys_d     = '0;
    illegal_d = 1'b0;
    imm32     = '0;
    shamt_d   = '0;
    use_shamt = 1'b0;
    case (opcode)
      OPC_OP: begin
        opinfo_d[0] = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  alu_d[0] = 1'b1;
            3'b001:  alu_d[5] = 1'b1;
            3'b010:  alu_d[8] = 1'b1;
            3'b011:  alu_d[9] = 1'b1;
            3'b100:  alu_d[2] = 1'b1;
            3'b101:  alu_d[6] = 1'b1;
            3'b110:  alu_d[3] = 1'b1;
            default: alu_d[4] = 1'b1;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) alu_d[1] = 1'b1;
        else if (f7 == 7'b0100000 && f3 == 3'b101) alu_d[7] = 1'b1;
        else if (HAS_M && f7 == 7'b0000001) mdu_d[f3] = 1'b1;
        else illegal_d = 1'b1;
      end
      OPC_OP_IMM: begin
        opinfo_d[1] = 1'b1;
        imm32       = {{20{inst_i[31]}}, inst_i[31:20]};
        shamt_d     = RV64 ? inst_i[25:20] : {1'b0, inst_i[24:20]};
        case (f3)
          3'b000: alu_d[0] = 1'b1;
          3'b010: alu_d[8] = 1'b1;
          3'b011: alu_d[9] = 1'b1;
          3'b100: alu_d[2] = 1'b1;
          3'b110: alu_d[3] = 1'b1;
          3'b111: alu_d[4] = 1'b1;
          3'b001: begin
            use_shamt = 1'b1;
            if (shift_hi_zero) alu_d[5] = 1'b1;
            else illegal_d = 1'b1;
          end
          default: begin
            use_shamt = 1'b1;
            if (shift_hi_zero) alu_d[6] = 1'b1;
            else if (shift_hi_sra) alu_d[7] = 1'b1;
            else illegal_d = 1'b1;
          end
        endcase
      end
      OPC_OP_32: begin
        opinfo_d[2] = 1'b1;
        if (!RV64) illegal_d = 1'b1;
        else if (f7 == 7'b0000000 && f3 == 3'b000) alu_d[0] = 1'b1;
        else if (f7 == 7'b0000000 && f3 == 3'b001) alu_d[5] = 1'b1;
        else if (f7 == 7'b0000000 && f3 == 3'b101) alu_d[6] = 1'b1;
        else if (f7 == 7'b0100000 && f3 == 3'b000) alu_d[1] = 1'b1;
        else if (f7 == 7'b0100000 && f3 == 3'b101) alu_d[7] = 1'b1;
        else if (HAS_M && f7 == 7'b0000001 && (f3 == 3'b000 || f3[2])) mdu_d[f3] = 1'b1;
        else illegal_d = 1'b1;
      end
      OPC_OP_IMM32: begin
        opinfo_d[3] = 1'b1;
        imm32       = {{20{inst_i[31]}}, inst_i[31:20]};
        shamt_d     = {1'b0, inst_i[24:20]};
        if (!RV64) illegal_d = 1'b1;
        else if (f3 == 3'b000) alu_d[0] = 1'b1;
        else if (f3 == 3'b001 && f7 == 7'b0000000) begin
          alu_d[5]  = 1'b1;
          use_shamt = 1'b1;
        end else if (f3 == 3'b101 && f7 == 7'b0000000) begin
          alu_d[6]  = 1'b1;
          use_shamt = 1'b1;
        end else if (f3 == 3'b101 && f7 == 7'b0100000) begin
          alu_d[7]  = 1'b1;
          use_shamt = 1'b1;
        end else illegal_d = 1'b1;
      end
      OPC_BRANCH: begin
        opinfo_d[4] = 1'b1;
        imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        case (f3)
          3'b000:  br_d[0] = 1'b1;
          3'b001:  br_d[1] = 1'b1;
          3'b100:  br_d[2] = 1'b1;
          3'b101:  br_d[3] = 1'b1;
          3'b110:  br_d[4] = 1'b1;
          3'b111:  br_d[5] = 1'b1;
          default: illegal_d = 1'b1;
        endcase
      end
      OPC_JAL: begin
        opinfo_d[5] = 1'b1;
        imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      end
      OPC_JALR: begin
        opinfo_d[6] = 1'b1;
        imm32       = {{20{inst_i[31]}}, inst_i[31:20]};
        if (f3 != 3'b000) illegal_d = 1'b1;
      end
      OPC_LOAD: begin
        opinfo_d[7] = 1'b1;
        imm32       = {{20{inst_i[31]}}, inst_i[31:20]};
        case (f3)
          3'b000:  ld_d[0] = 1'b1;
          3'b001:  ld_d[1] = 1'b1;
          3'b010:  ld_d[2] = 1'b1;
          3'b011:  if (RV64) ld_d[3] = 1'b1; else illegal_d = 1'b1;
          3'b100:  ld_d[4] = 1'b1;
          3'b101:  ld_d[5] = 1'b1;
          3'b110:  if (RV64) ld_d[6] = 1'b1; else illegal_d = 1'b1;
          default: illegal_d = 1'b1;
        endcase
      end
      OPC_STORE: begin
        opinfo_d[8] = 1'b1;
        imm32       = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        case (f3)
          3'b000:  st_d[0] = 1'b1;
          3'b001:  st_d[1] = 1'b1;
          3'b010:  st_d[2] = 1'b1;
          3'b011:  if (RV64) st_d[3] = 1'b1; else illegal_d = 1'b1;
          default: illegal_d = 1'b1;
        endcase
      end
      OPC_LUI: begin
        opinfo_d[9] = 1'b1;
        imm32       = {inst_i[31:12], 12'h000};
      end
      OPC_AUIPC: begin
        opinfo_d[10] = 1'b1;
        imm32        = {inst_i[31:12], 12'h000};
      end
      OPC_SYSTEM: begin
        opinfo_d[11] = 1'b1;
        if (inst_i == 32'h0000_0073) sys_d[0] = 1'b1;
        else if (inst_i == 32'h0010_0073) sys_d[1] = 1'b1;
        else illegal_d = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
    // An illegal encoding travels downstream with every class/op bit cleared.
    if (illegal_d) begin
      opinfo_d  = '0;
      alu_d     = '0;
      mdu_d     = '0;
      br_d      = '0;
      ld_d      = '0;
      st_d      = '0;
      sys_d     = '0;
      imm32     = '0;
      use_shamt = 1'b0;
    end
  end

  assign wen_d = ~illegal_d & ~(opinfo_d[4] | opinfo_d[8] | opinfo_d[11]);
  assign imm_d = use_shamt ? {{(XLEN-6){1'b0}}, shamt_d} : XLEN'($signed(imm32));

  always_comb begin
    case (state)
      EMPTY:   in_ready_o = 1'b1;
      FULL:    in_ready_o = out_ready_i & ~opinfo_o[11];
      default: in_ready_o = 1'b0;
    endcase
  end

  assign out_valid_o = (state == FULL);
  assign accept      = in_valid_i & in_ready_o & ~flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      pc_o      <= '0;
      opinfo_o  <= '0;
      alu_o     <= '0;
      mdu_o     <= '0;
      branch_o  <= '0;
      load_o    <= '0;
      store_o   <= '0;
      sys_o     <= '0;
      illegal_o <= 1'b0;
      wen_reg_o <= 1'b0;
      rd_o      <= '0;
      rs1_o     <= '0;
      rs2_o     <= '0;
      imm_o     <= '0;
    end else begin
      if (accept) begin
        pc_o      <= pc_i;
        opinfo_o  <= opinfo_d;
        alu_o     <= alu_d;
        mdu_o     <= mdu_d;
        branch_o  <= br_d;
        load_o    <= ld_d;
        store_o   <= st_d;
        sys_o     <= sys_d;
        illegal_o <= illegal_d;
        wen_reg_o <= wen_d;
        rd_o      <= inst_i[11:7];
        rs1_o     <= inst_i[19:15];
        rs2_o     <= inst_i[24:20];
        imm_o     <= imm_d;
      end
      if (flush_i) state <= EMPTY;
      else begin
        case (state)
          EMPTY: if (in_valid_i) state <= FULL;
          FULL: begin
            if (out_ready_i) begin
              if (opinfo_o[11]) state <= SERIAL;
              else if (in_valid_i) state <= FULL;
              else state <= EMPTY;
            end
          end
          default: if (sys_done_i) state <= EMPTY;
        endcase
      end
    end
  end

endmodule
